id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
//  Sequences the ID stage of the 5-stage MIPS pipeline, which holds the register read, sign-extend and branch compare.
//  - Detects load-use and branch-operand hazards.
//  - Generates PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush on taken branches.
//  - Freezes the whole pipe while data memory is busy.
// PARAMETERS
//  REG_AW   5   register-address width
//  CNT_W    16  width of statistics counters (HAZARD_STATS_EN only)
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  id_rs         in   REG_AW ID-stage rs field
//  id_rt         in   REG_AW ID-stage rt field
//  id_use_rs     in   1      ID instruction reads rs
//  id_use_rt     in   1      ID instruction reads rt
//  id_branch     in   1      ID instruction is beq/bne (compared in ID)
//  id_br_taken   in   1      ID branch comparator result, valid when id_branch
//  ex_rd         in   REG_AW EX-stage destination register
//  ex_reg_write  in   1      EX instruction writes a register
//  ex_mem_read   in   1      EX instruction is a load
//  mem_rd        in   REG_AW MEM-stage destination register
//  mem_mem_read  in   1      MEM instruction is a load
//  dmem_busy     in   1      data memory not ready this cycle
//  pc_write      out  1      PC update enable
//  ifid_write    out  1      IF/ID register enable
//  idex_bubble   out  1      force ID/EX control fields to zero (NOP)
//  ifid_flush    out  1      clear IF/ID on next edge (taken branch)
//  pipe_freeze   out  1      hold ID/EX, EX/MEM and MEM/WB registers
//  stall_cycles  out  CNT_W  cycles with pc_write=0 (HAZARD_STATS_EN only)
//  flush_count   out  CNT_W  taken-branch flushes (HAZARD_STATS_EN only)
// BEHAVIOUR
//  - Match rule: reg X hazards with stage S iff use_X && X!=0 && X==S_rd and the stage condition holds.
//  - Raw hazards, combinational from the current inputs:
//    - LU: load-use. ID matches ex_rd with ex_mem_read (any instruction).
//    - BE: branch on EX ALU result. id_branch && match ex_rd && ex_reg_write && !ex_mem_read.
//    - BL: branch on EX load. id_branch && match ex_rd && ex_mem_read.
//    - BM: branch on MEM load. id_branch && match mem_rd && mem_mem_read.
//  - The load-use match on ex_rd is the LU/BL condition, split by id_branch.
//  - FSM, registered, two states: RUN, HOLD2. Reset forces RUN.
//    - RUN -> HOLD2 when BL && !dmem_busy. Otherwise stay in RUN.
//    - HOLD2 -> RUN unconditionally, unless dmem_busy, in which case stay in HOLD2.
//  - Output priority, highest first:
//    - FREEZE: dmem_busy=1. pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0. State holds.
//    - STALL: state==HOLD2, or LU, BE, BL or BM. pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
//    - FLUSH: id_branch && id_br_taken and no stall. pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0.
//    - NORMAL: pc_write=1, ifid_write=1, all other outputs 0.
//  - Stall latencies:
//    - LU, BE, BM: 1 bubble.
//    - BL: 2 bubbles (RUN cycle plus HOLD2 cycle).
//    - A taken branch flushes one fetched instruction.
//  - Outputs are combinational from state and inputs. No registered outputs other than the stats counters.
//  - While rst_n=0: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pipe_freeze=0.
//  - Reset asserted mid-stall: the FSM returns to RUN immediately. The pending HOLD2 is discarded.
//  - Register $0 never causes a hazard.
//  - Simultaneous taken branch and stall: the stall wins. The flush occurs on the first non-stalled cycle.
// CONFIGURATION
//  - HAZARD_STATS_EN defined: two counters, reset to 0, saturate at all-ones, not incremented during dmem_busy.
//    - stall_cycles increments on each STALL cycle.
//    - flush_count increments on each FLUSH cycle.
//  - HAZARD_STATS_EN undefined: ports stall_cycles and flush_count are absent. No counter logic.
// STRUCTURE
//  - Shared package or header mips_pipe_pkg:
//    - REG_AW.
//    - FSM state encodings ST_RUN=1'b0, ST_HOLD2=1'b1.
//    - Opcode constants OP_BEQ, OP_BNE, OP_LW used by the decoder that drives id_branch and ex_mem_read.
//  - Sub-module hazard_match: pure compare of (use, addr, stage_rd, stage_cond) giving a 1-bit hit.
//    - Instantiated four times (rs/rt against EX and MEM).
//  - FSM and stats counters live in the top module.
// TESTING
//  1. Load-use: EX lw $8 (ex_mem_read=1, ex_rd=8); ID add reading rs=8.
//     -> 1 cycle pc_write=0, idex_bubble=1; next cycle normal.
//  2. Branch on EX load: EX lw $9; ID beq rt=9.
//     -> 2 consecutive stall cycles (RUN then HOLD2), then pc_write=1.
//  3. Branch on ALU and MEM load:
//     - EX add $5 with ID bne rs=5 -> 1 stall.
//     - MEM lw $6 with ID beq rt=6 -> 1 stall.
//     - rs=rt=0 with ex_rd=0 -> no stall.
//  4. Taken branch: id_branch=1, id_br_taken=1, no hazard.
//     -> ifid_flush=1, pc_write=1 for exactly 1 cycle.
//     - Same cycle with LU active -> stall only, flush on the following cycle.
//  5. Freeze: dmem_busy=1 for 3 cycles during HOLD2.
//     -> pipe_freeze=1, state stays HOLD2; after release 1 remaining stall cycle.
//  6. Reset and stats:
//     - Drop rst_n in HOLD2 -> reset outputs, RUN after release.
//     - With HAZARD_STATS_EN, scenarios 1+4 give stall_cycles=1, flush_count=1.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types and constants: register width, ID hazard FSM
// encoding, hazard/control bundles and decoder opcodes.
package mips_pipe_pkg;

  localparam int unsigned REG_AW      = 5;
  localparam int unsigned STATS_CNT_W = 16;
  localparam int unsigned OPCODE_W    = 6;

  // Opcodes the decoder uses to raise id_branch and ex_mem_read
  localparam logic [OPCODE_W-1:0] OP_BEQ = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_LW  = 6'h23;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_HOLD2 = 1'b1
  } hz_state_e;

  // Raw hazard classes seen by the ID instruction this cycle
  typedef struct packed {
    logic lu;
    logic be;
    logic bl;
    logic bm;
  } hz_raw_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic pipe_freeze;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NORMAL = hz_ctrl_t'(5'b11000);
  localparam hz_ctrl_t CTRL_STALL  = hz_ctrl_t'(5'b00100);
  localparam hz_ctrl_t CTRL_FLUSH  = hz_ctrl_t'(5'b11010);
  localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(5'b00001);
  localparam hz_ctrl_t CTRL_RESET  = hz_ctrl_t'(5'b00100);

  function automatic logic is_branch_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_load_op(input logic [OPCODE_W-1:0] op);
    return op == OP_LW;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against one later-stage destination.
// $0 is hardwired to zero and can never carry a dependency.
module hazard_match #(
  parameter int unsigned AW = 5
) (
  input  logic          use_reg,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] stage_rd,
  input  logic          stage_cond,
  output logic          hit_c
);

  assign hit_c = use_reg && (addr != '0) && (addr == stage_rd) && stage_cond;

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use / branch-operand stalls, taken-branch
// flush and dmem freeze. Define HAZARD_STATS_EN to add stall/flush counters.
module id_hazard_ctrl #(
  parameter int unsigned REG_AW = mips_pipe_pkg::REG_AW
`ifdef HAZARD_STATS_EN
  , parameter int unsigned CNT_W = mips_pipe_pkg::STATS_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_br_taken,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_mem_read,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              pipe_freeze
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_count
`endif
);

  import mips_pipe_pkg::*;

  hz_state_e state, state_nxt;
  hz_raw_t   raw;
  hz_ctrl_t  ctrl;
  logic      rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic      ex_hit, mem_hit;
  logic      stall_c;
  logic      flush_c;

  // EX compare is unconditioned; the load / ALU split is applied below
  hazard_match #(.AW(REG_AW)) u_rs_ex (
    .use_reg    (id_use_rs),
    .addr       (id_rs),
    .stage_rd   (ex_rd),
    .stage_cond (1'b1),
    .hit_c      (rs_ex_hit)
  );

  hazard_match #(.AW(REG_AW)) u_rt_ex (
    .use_reg    (id_use_rt),
    .addr       (id_rt),
    .stage_rd   (ex_rd),
    .stage_cond (1'b1),
    .hit_c      (rt_ex_hit)
  );

  hazard_match #(.AW(REG_AW)) u_rs_mem (
    .use_reg    (id_use_rs),
    .addr       (id_rs),
    .stage_rd   (mem_rd),
    .stage_cond (mem_mem_read),
    .hit_c      (rs_mem_hit)
  );

  hazard_match #(.AW(REG_AW)) u_rt_mem (
    .use_reg    (id_use_rt),
    .addr       (id_rt),
    .stage_rd   (mem_rd),
    .stage_cond (mem_mem_read),
    .hit_c      (rt_mem_hit)
  );

  assign ex_hit  = rs_ex_hit || rt_ex_hit;
  assign mem_hit = rs_mem_hit || rt_mem_hit;

  always_comb begin
    raw    = '0;
    raw.lu = ex_hit && ex_mem_read && !id_branch;
    raw.bl = ex_hit && ex_mem_read && id_branch;
    raw.be = ex_hit && id_branch && ex_reg_write && !ex_mem_read;
    raw.bm = mem_hit && id_branch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next state and pipeline controls; freeze outranks stall outranks flush
  always_comb begin
    state_nxt = state;
    ctrl      = CTRL_NORMAL;
    stall_c   = (state == ST_HOLD2) || (|raw);
    flush_c   = 1'b0;

    unique case (state)
      ST_RUN:   if (raw.bl && !dmem_busy) state_nxt = ST_HOLD2;
      ST_HOLD2: if (!dmem_busy)           state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase

    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else if (dmem_busy) begin
      ctrl = CTRL_FREEZE;
    end else if (stall_c) begin
      ctrl = CTRL_STALL;
    end else if (id_branch && id_br_taken) begin
      ctrl    = CTRL_FLUSH;
      flush_c = 1'b1;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_bubble = ctrl.idex_bubble;
  assign ifid_flush  = ctrl.ifid_flush;
  assign pipe_freeze = ctrl.pipe_freeze;

`ifdef HAZARD_STATS_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !dmem_busy && stall_c;
  assign flush_inc = flush_c;

  // Saturating event counters, frozen while dmem is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_inc && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_count  != '1)) flush_count  <= flush_count  + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed cycle vectors push expected
// controls; a negedge monitor pops and compares.
module tb_id_hazard_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;

  localparam logic [4:0] E_NORM  = 5'b11000;
  localparam logic [4:0] E_STALL = 5'b00100;
  localparam logic [4:0] E_FLUSH = 5'b11010;
  localparam logic [4:0] E_FRZ   = 5'b00001;
  localparam logic [4:0] E_RST   = 5'b00100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic          id_use_rs, id_use_rt, id_branch, id_br_taken;
  logic          ex_reg_write, ex_mem_read, mem_mem_read, dmem_busy;
  logic          pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;
  int exp_flushes = 0;
  bit drv_done = 1'b0;

  logic [4:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_branch    (id_branch),
    .id_br_taken  (id_br_taken),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .mem_rd       (mem_rd),
    .mem_mem_read (mem_mem_read),
    .dmem_busy    (dmem_busy),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .pipe_freeze  (pipe_freeze)
`ifdef HAZARD_STATS_EN
    , .stall_cycles (stall_cycles)
    , .flush_count  (flush_count)
`endif
  );

  // One pipeline cycle: drive inputs, record expectation, advance past the edge
  task automatic cyc(input string nm, input logic rn, input logic busy,
                     input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt,
                     input logic br, input logic tk,
                     input logic [4:0] exrd, input logic exrw, input logic exmr,
                     input logic [4:0] mrd, input logic mmr,
                     input logic [4:0] exp);
    rst_n = rn;  dmem_busy = busy;
    id_rs = rs;  id_use_rs = urs;  id_rt = rt;  id_use_rt = urt;
    id_branch = br;  id_br_taken = tk;
    ex_rd = exrd;  ex_reg_write = exrw;  ex_mem_read = exmr;
    mem_rd = mrd;  mem_mem_read = mmr;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    if (!rn) begin
      exp_stalls = 0;
      exp_flushes = 0;
    end else if (!busy) begin
      if (exp == E_STALL) exp_stalls++;
      else if (exp == E_FLUSH) exp_flushes++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle once the driver has issued a vector
  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] exp;
    string      nm;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got pc/ifid/bub/flush/frz=%b expected %b", nm, got, exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;  dmem_busy = 1'b0;
    id_rs = '0;  id_rt = '0;  id_use_rs = 1'b0;  id_use_rt = 1'b0;
    id_branch = 1'b0;  id_br_taken = 1'b0;
    ex_rd = '0;  ex_reg_write = 1'b0;  ex_mem_read = 1'b0;
    mem_rd = '0;  mem_mem_read = 1'b0;
    @(posedge clk);
    #1;
    //  name            rn busy rs urs rt urt br tk exrd rw mr mrd mr  exp
    cyc("reset0",       0, 0,   0, 0,  0, 0,  0, 0, 0,   0, 0, 0,  0, E_RST);
    cyc("reset1",       0, 0,   8, 1,  9, 1,  1, 1, 8,   1, 1, 9,  1, E_RST);
    cyc("idle",         1, 0,   0, 0,  0, 0,  0, 0, 0,   0, 0, 0,  0, E_NORM);
    // load-use
    cyc("lu_stall",     1, 0,   8, 1,  3, 1,  0, 0, 8,   1, 1, 0,  0, E_STALL);
    cyc("lu_release",   1, 0,   8, 1,  3, 1,  0, 0, 0,   0, 0, 8,  1, E_NORM);
    cyc("lu_rt_stall",  1, 0,   2, 1, 11, 1,  0, 0, 11,  1, 1, 0,  0, E_STALL);
    cyc("lu_nouse",     1, 0,   8, 0,  0, 0,  0, 0, 8,   1, 1, 0,  0, E_NORM);
    cyc("lu_r0",        1, 0,   0, 1,  0, 1,  0, 0, 0,   1, 1, 0,  0, E_NORM);
    // branch on EX load: two bubbles
    cyc("bl_run",       1, 0,   4, 1,  9, 1,  1, 0, 9,   1, 1, 0,  0, E_STALL);
    cyc("bl_hold2",     1, 0,   4, 1,  9, 1,  1, 0, 0,   0, 0, 9,  1, E_STALL);
    cyc("bl_done",      1, 0,   4, 1,  9, 1,  1, 0, 0,   0, 0, 0,  0, E_NORM);
    // branch on EX ALU result and on MEM load
    cyc("be_stall",     1, 0,   5, 1,  2, 1,  1, 0, 5,   1, 0, 0,  0, E_STALL);
    cyc("be_done",      1, 0,   5, 1,  2, 1,  1, 0, 0,   0, 0, 5,  0, E_NORM);
    cyc("be_nowrite",   1, 0,   5, 1,  2, 1,  1, 0, 5,   0, 0, 0,  0, E_NORM);
    cyc("bm_stall",     1, 0,   1, 1,  6, 1,  1, 0, 0,   0, 0, 6,  1, E_STALL);
    cyc("bm_done",      1, 0,   1, 1,  6, 1,  1, 0, 0,   0, 0, 0,  0, E_NORM);
    cyc("br_r0",        1, 0,   0, 1,  0, 1,  1, 0, 0,   1, 1, 0,  1, E_NORM);
    // taken branch
    cyc("flush",        1, 0,   1, 1,  2, 1,  1, 1, 0,   0, 0, 0,  0, E_FLUSH);
    cyc("post_flush",   1, 0,   0, 0,  0, 0,  0, 0, 0,   0, 0, 0,  0, E_NORM);
    cyc("tk_be_stall",  1, 0,   3, 1,  0, 0,  1, 1, 3,   1, 0, 0,  0, E_STALL);
    cyc("tk_be_flush",  1, 0,   3, 1,  0, 0,  1, 1, 0,   0, 0, 0,  0, E_FLUSH);
    cyc("tk_bl_run",    1, 0,   7, 1,  2, 1,  1, 1, 7,   1, 1, 0,  0, E_STALL);
    cyc("tk_bl_hold2",  1, 0,   7, 1,  2, 1,  1, 1, 0,   0, 0, 7,  1, E_STALL);
    cyc("tk_bl_flush",  1, 0,   7, 1,  2, 1,  1, 1, 0,   0, 0, 0,  0, E_FLUSH);
    // freeze during HOLD2
    cyc("fz_bl_run",    1, 0,   4, 1,  9, 1,  1, 0, 9,   1, 1, 0,  0, E_STALL);
    cyc("fz_hold2_a",   1, 1,   4, 1,  9, 1,  1, 0, 0,   0, 0, 9,  1, E_FRZ);
    cyc("fz_hold2_b",   1, 1,   4, 1,  9, 1,  1, 0, 0,   0, 0, 9,  1, E_FRZ);
    cyc("fz_hold2_c",   1, 1,   4, 1,  9, 1,  1, 0, 0,   0, 0, 9,  1, E_FRZ);
    cyc("fz_release",   1, 0,   4, 1,  9, 1,  1, 0, 0,   0, 0, 0,  0, E_STALL);
    cyc("fz_done",      1, 0,   4, 1,  9, 1,  1, 0, 0,   0, 0, 0,  0, E_NORM);
    // freeze in RUN blocks the RUN->HOLD2 transition
    cyc("fz_run_bl",    1, 1,   4, 1,  9, 1,  1, 0, 9,   1, 1, 0,  0, E_FRZ);
    cyc("fz_run_bl_go", 1, 0,   4, 1,  9, 1,  1, 0, 9,   1, 1, 0,  0, E_STALL);
    cyc("fz_run_hold2", 1, 0,   4, 1,  9, 1,  1, 0, 0,   0, 0, 0,  0, E_STALL);
    cyc("fz_run_done",  1, 0,   4, 1,  9, 1,  1, 0, 0,   0, 0, 0,  0, E_NORM);
    cyc("fz_taken",     1, 1,   1, 1,  2, 1,  1, 1, 0,   0, 0, 0,  0, E_FRZ);
    cyc("fz_taken_go",  1, 0,   1, 1,  2, 1,  1, 1, 0,   0, 0, 0,  0, E_FLUSH);
    // reset dropped while in HOLD2
    cyc("rst_bl_run",   1, 0,   4, 1,  9, 1,  1, 0, 9,   1, 1, 0,  0, E_STALL);
    cyc("rst_mid",      0, 0,   4, 1,  9, 1,  1, 0, 0,   0, 0, 0,  0, E_RST);
    cyc("rst_after",    1, 0,   4, 1,  9, 1,  1, 0, 0,   0, 0, 0,  0, E_NORM);
    // load-use then taken branch, for the statistics counters
    cyc("st_lu",        1, 0,   8, 1,  3, 1,  0, 0, 8,   1, 1, 0,  0, E_STALL);
    cyc("st_lu_rel",    1, 0,   8, 1,  3, 1,  0, 0, 0,   0, 0, 8,  1, E_NORM);
    cyc("st_flush",     1, 0,   1, 1,  2, 1,  1, 1, 0,   0, 0, 0,  0, E_FLUSH);
    cyc("st_idle",      1, 0,   0, 0,  0, 0,  0, 0, 0,   0, 0, 0,  0, E_NORM);
    drv_done = 1'b1;
  end

  // Drain the scoreboard within a bounded number of cycles, then summarise
  initial begin
    int waited;
    waited = 0;
    wait (drv_done);
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cycles !== CW'(exp_stalls)) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls);
    end
    checks++;
    if (flush_count !== CW'(exp_flushes)) begin
      errors++;
      $display("FAIL flush_count: got %0d expected %0d", flush_count, exp_flushes);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
